sc_stream_decoder: RTL and testbench

//  Stochastic-to-binary converter: counts 1s in a unipolar bitstream over a window of 2^DATAWD valid bits.

---
 rtl/sc_stream_decoder_if.sv | 39 +++
 rtl/sc_stream_decoder.sv | 123 ++++++++++++
 tb/tb_sc_stream_decoder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sc_stream_decoder_if.sv
// Handshake bundle between a stochastic bitstream source/consumer and
// sc_stream_decoder. The decoder uses the slave view; the environment
// driving bits and accepting results uses the master view.
interface sc_stream_decoder_if #(
    parameter int DATAWD = 8
);
    logic              iStart;
    logic              iBit;
    logic              iBitValid;
    logic              iReady;
    logic [DATAWD-1:0] oValue;
    logic              oValid;
    logic              oSat;
    logic              oBusy;

    // Decoder side
    modport slave (
        input  iStart,
        input  iBit,
        input  iBitValid,
        input  iReady,
        output oValue,
        output oValid,
        output oSat,
        output oBusy
    );

    // Bitstream producer / result consumer side
    modport master (
        output iStart,
        output iBit,
        output iBitValid,
        output iReady,
        input  oValue,
        input  oValid,
        input  oSat,
        input  oBusy
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary converter. Counts the 1s in a unipolar bitstream over
// a window of exactly 2^DATAWD valid bits and presents the count on a
// valid/ready handshake. A full window of ones (2^DATAWD) saturates to
// all-ones and raises oSat. With Sobol-driven comparator encoders, a value v
// encoded over one full period decodes back to exactly v.
module sc_stream_decoder #(
    parameter int DATAWD       = 8,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    sc_stream_decoder_if.slave  bus
);

    // Counters are one bit wider than the result so that a window of all
    // ones (2^DATAWD) and the final bit index are both representable.
    localparam logic [DATAWD:0] LP_WIN  = {1'b1, {DATAWD{1'b0}}};
    localparam logic [DATAWD:0] LP_LAST = {1'b0, {DATAWD{1'b1}}};
    localparam logic [DATAWD:0] LP_ONE  = {{DATAWD{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_clr;
    logic                w_last;
    logic [DATAWD:0]     r_cnt;
    logic [DATAWD:0]     r_idx;
    logic [DATAWD:0]     w_cnt_inc;
    logic                w_full;
    logic [DATAWD-1:0]   r_value;
    logic                r_sat;

    // Count including the bit on the input this cycle; only committed when
    // the bit is valid during ACCUM.
    assign w_cnt_inc = r_cnt + {{DATAWD{1'b0}}, bus.iBit};
    assign w_full    = (w_cnt_inc == LP_WIN);

    // The bit that brings the index to 2^DATAWD closes the window and is
    // itself part of the count.
    assign w_last = (r_state == S_ACCUM) && bus.iBitValid && (r_idx == LP_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; w_clr zeroes the counters as a new window opens
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The bit on the start cycle is not counted: the counters
                // are being cleared on this edge.
                if (bus.iStart) begin
                    w_state_nxt = S_ACCUM;
                    w_clr       = 1'b1;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                // Anything on the bit inputs during HOLD is dropped, so with
                // auto-restart the next window begins one cycle later.
                if (bus.iReady) begin
                    if (AUTO_RESTART) begin
                        w_state_nxt = S_ACCUM;
                        w_clr       = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Ones count and bit index; gaps in iBitValid leave both untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_clr) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if ((r_state == S_ACCUM) && bus.iBitValid) begin
            r_idx <= r_idx + LP_ONE;
            r_cnt <= w_cnt_inc;
        end
    end

    // Result registers, loaded as the window closes and held (through HOLD
    // and afterwards in IDLE) until the next window closes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
            r_sat   <= 1'b0;
        end else if (w_last) begin
            r_value <= w_full ? {DATAWD{1'b1}} : w_cnt_inc[DATAWD-1:0];
            r_sat   <= w_full;
        end
    end

    assign bus.oValue = r_value;
    assign bus.oSat   = r_sat;
    assign bus.oValid = (r_state == S_HOLD);
    assign bus.oBusy  = (r_state == S_ACCUM);

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Bench for sc_stream_decoder: one instance without auto-restart (A) and one
// with auto-restart and iReady tied high (B). Expected results are queued as
// each window is started and compared when the decoder hands a result over.
module tb_sc_stream_decoder;

    localparam int DW = 8;

    typedef struct {
        int v;
        int s;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_start = 0;
    int   t_valid = -1;
    exp_t qa[$];
    exp_t qb[$];

    sc_stream_decoder_if #(.DATAWD(DW)) bus_a ();
    sc_stream_decoder_if #(.DATAWD(DW)) bus_b ();

    sc_stream_decoder #(.DATAWD(DW), .AUTO_RESTART(1'b0)) u_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    sc_stream_decoder #(.DATAWD(DW), .AUTO_RESTART(1'b1)) u_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // andMUL-style encoder against a 1-D Sobol sequence (bit-reversed index):
    // over 256 indices the sequence visits 0..255 once, so exactly v ones.
    function automatic logic sob(input int v, input int i);
        int r;
        r = 0;
        for (int k = 0; k < DW; k++) r |= ((i >> k) & 1) << (DW - 1 - k);
        return (v > r);
    endfunction

    // Drive inputs for one cycle; they change 1 time unit after the edge
    task automatic drv_a(input logic s, input logic b, input logic v);
        bus_a.iStart    = s;
        bus_a.iBit      = b;
        bus_a.iBitValid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_b(input logic s, input logic b, input logic v);
        bus_b.iStart    = s;
        bus_b.iBit      = b;
        bus_b.iBitValid = v;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for A: compare on every handshake; also note the first
    // cycle oValid is seen for latency checks
    always @(negedge clk) begin
        if (!rst && bus_a.oValid) begin
            if (t_valid < 0) t_valid = cyc;
            if (bus_a.iReady) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    chk("a_value", int'(bus_a.oValue), e.v);
                    chk("a_sat", int'(bus_a.oSat), e.s);
                end
            end
        end
    end

    // Scoreboard for B
    always @(negedge clk) begin
        if (!rst && bus_b.oValid && bus_b.iReady) begin
            if (qb.size() == 0) begin
                chk("b_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_value", int'(bus_b.oValue), e.v);
                chk("b_sat", int'(bus_b.oSat), e.s);
            end
        end
    end

    initial begin
        bus_a.iStart = 0; bus_a.iBit = 0; bus_a.iBitValid = 0; bus_a.iReady = 1;
        bus_b.iStart = 0; bus_b.iBit = 0; bus_b.iBitValid = 0; bus_b.iReady = 1;
        drv_a(0, 0, 0);
        drv_a(0, 0, 0);
        rst = 0;

        // Reset state
        chk("rst_valid", int'(bus_a.oValid), 0);
        chk("rst_busy", int'(bus_a.oBusy), 0);
        chk("rst_value", int'(bus_a.oValue), 0);
        chk("rst_sat", int'(bus_a.oSat), 0);
        chk("rst_b_busy", int'(bus_b.oBusy), 0);

        // 1: v=100 Sobol stream; bit on the start cycle must be ignored.
        // oValid appears in the 257th cycle after the iStart cycle.
        qa.push_back('{100, 0});
        t_valid = -1;
        t_start = cyc;
        drv_a(1, 1, 1);
        chk("t1_busy", int'(bus_a.oBusy), 1);
        for (int i = 0; i < 256; i++) drv_a(0, sob(100, i), 1);
        drv_a(0, 0, 0);
        chk("t1_latency", t_valid - t_start, 257);
        chk("t1_idle_valid", int'(bus_a.oValid), 0);
        chk("t1_idle_busy", int'(bus_a.oBusy), 0);

        // 2: all ones saturates, all zeros gives 0
        qa.push_back('{255, 1});
        drv_a(1, 0, 0);
        for (int i = 0; i < 256; i++) drv_a(0, 1, 1);
        drv_a(0, 0, 0);
        qa.push_back('{0, 0});
        drv_a(1, 1, 0);
        for (int i = 0; i < 256; i++) drv_a(0, 0, 1);
        drv_a(0, 0, 0);

        // 3: valid every other cycle, ones on odd valid bits; invalid
        // cycles carry iBit=1 which must not count
        qa.push_back('{128, 0});
        t_valid = -1;
        t_start = cyc;
        drv_a(1, 0, 0);
        for (int i = 0; i < 256; i++) begin
            drv_a(0, logic'(i % 2), 1);
            drv_a(0, 1, 0);
        end
        chk("t3_latency", t_valid - t_start, 512);
        drv_a(0, 0, 0);

        // 4: backpressure for 20 cycles with bits and starts toggling
        bus_a.iReady = 0;
        qa.push_back('{100, 0});
        drv_a(1, 0, 0);
        for (int i = 0; i < 256; i++) drv_a(0, sob(100, i), 1);
        for (int k = 0; k < 20; k++) begin
            chk("t4_hold_valid", int'(bus_a.oValid), 1);
            chk("t4_hold_value", int'(bus_a.oValue), 100);
            drv_a(logic'(k % 2), logic'(k % 2), 1);
        end
        bus_a.iReady = 1;
        drv_a(0, 1, 1);
        chk("t4_rel_valid", int'(bus_a.oValid), 0);
        chk("t4_rel_busy", int'(bus_a.oBusy), 0);
        drv_a(0, 1, 1);
        drv_a(0, 1, 1);
        chk("t4_idle_busy", int'(bus_a.oBusy), 0);
        chk("t4_idle_value", int'(bus_a.oValue), 100);

        // 5: reset at valid bit 50, then a fresh window of zeros
        drv_a(1, 0, 0);
        for (int i = 0; i < 49; i++) drv_a(0, 1, 1);
        rst = 1;
        drv_a(0, 1, 1);
        rst = 0;
        chk("t5_rst_busy", int'(bus_a.oBusy), 0);
        chk("t5_rst_valid", int'(bus_a.oValid), 0);
        chk("t5_rst_value", int'(bus_a.oValue), 0);
        qa.push_back('{0, 0});
        t_valid = -1;
        t_start = cyc;
        drv_a(1, 0, 0);
        for (int i = 0; i < 256; i++) drv_a(0, 0, 1);
        drv_a(0, 0, 0);
        chk("t5_latency", t_valid - t_start, 257);

        // 6: auto-restart, 37 then 200, one dropped HOLD cycle between;
        // iStart pulses during ACCUM are ignored
        qb.push_back('{37, 0});
        drv_b(1, 0, 0);
        for (int i = 0; i < 256; i++) drv_b(logic'(i % 50 == 7), sob(37, i), 1);
        chk("t6_hold_valid", int'(bus_b.oValid), 1);
        chk("t6_hold_busy", int'(bus_b.oBusy), 0);
        qb.push_back('{200, 0});
        drv_b(1, 1, 1);
        chk("t6_resume_busy", int'(bus_b.oBusy), 1);
        chk("t6_resume_valid", int'(bus_b.oValid), 0);
        for (int i = 0; i < 256; i++) drv_b(logic'(i % 64 == 3), sob(200, i), 1);
        chk("t6_hold2_valid", int'(bus_b.oValid), 1);
        drv_b(0, 0, 0);
        drv_b(0, 0, 0);

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
